// File: rtl/fifo_wr_ctrl.sv
// Write-domain controller of the async FIFO: binary RAM address, Gray pointer, FULL/ALMOST_FULL, free count.
// Define FIFO_WR_OVF_EN to build the sticky overflow flag; otherwise OVF is tied low and OVF_CLR unused.
module fifo_wr_ctrl #(
  parameter int ADDR_W   = 3,
  parameter int AFULL_TH = 2
) (
  input  logic              W_CLK,
  input  logic              W_RST,
  input  logic              WINC,
  input  logic [ADDR_W:0]   WQ2_RPTR,
  input  logic              OVF_CLR,
  output logic              WEN,
  output logic [ADDR_W-1:0] WADDR,
  output logic [ADDR_W:0]   WPTR,
  output logic              FULL,
  output logic              ALMOST_FULL,
  output logic [ADDR_W:0]   WFREE,
  output logic              OVF
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] DEPTH     = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [PW-1:0] AFULL_LIM = PW'(AFULL_TH);

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b = g;
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] wbin_q, wbin_d;
  logic [PW-1:0] wptr_q, wgray_d;
  logic [PW-1:0] wfree_q, wfree_d;
  logic [PW-1:0] rbin_s, used_s;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          wen_s;

  // Next pointer and flags; flags use the next pointer so FULL rises right after the filling write.
  always_comb begin
    wen_s   = WINC & ~full_q;
    wbin_d  = wbin_q + {{ADDR_W{1'b0}}, wen_s};
    wgray_d = wbin_d ^ (wbin_d >> 1);
    rbin_s  = gray2bin(WQ2_RPTR);
    used_s  = wbin_d - rbin_s;
    wfree_d = DEPTH - used_s;
    full_d  = (wgray_d == {~WQ2_RPTR[ADDR_W:ADDR_W-1], WQ2_RPTR[ADDR_W-2:0]});
    afull_d = (wfree_d <= AFULL_LIM);
  end

  // Pointer and flag registers.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      wbin_q  <= {PW{1'b0}};
      wptr_q  <= {PW{1'b0}};
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      wfree_q <= DEPTH;
    end else begin
      wbin_q  <= wbin_d;
      wptr_q  <= wgray_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      wfree_q <= wfree_d;
    end
  end

  assign WEN         = wen_s;
  assign WADDR       = wbin_q[ADDR_W-1:0];
  assign WPTR        = wptr_q;
  assign FULL        = full_q;
  assign ALMOST_FULL = afull_q;
  assign WFREE       = wfree_q;

`ifdef FIFO_WR_OVF_EN
  logic ovf_q, ovf_d;

  // Sticky overflow: a blocked write outranks a clear in the same cycle.
  always_comb begin
    if (WINC & full_q) begin
      ovf_d = 1'b1;
    end else if (OVF_CLR) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Overflow flag register.
  always_ff @(posedge W_CLK or negedge W_RST) begin
    if (!W_RST) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
    end
  end

  assign OVF = ovf_q;
`else
  logic unused_ovf_clr_s;
  assign unused_ovf_clr_s = OVF_CLR;
  assign OVF = 1'b0;
`endif

endmodule
